// File: rtl/ps2_receiver_if.sv
// Pin-side and decoder-side signals of the PS/2 receiver.
// slave = receiver, master = whatever drives the pins and consumes scan codes.
interface ps2_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic       frame_error;
    logic       busy;

    modport slave (
        input  ps2_clk, ps2_data,
        output scan_code, scan_ready, frame_error, busy
    );

    modport master (
        output ps2_clk, ps2_data,
        input  scan_code, scan_ready, frame_error, busy
    );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host deserializer: synchronize, deglitch the clock, shift in
// 11-bit frames and emit one scan_ready or frame_error pulse per frame.
module ps2_receiver #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_receiver_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_clk_q, filt_clk_d, filt_prev_q;
    logic [3:0]    filt_cnt_q, filt_cnt_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_ok_q, parity_ok_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          scan_ready_q, scan_ready_d;
    logic          frame_error_q, frame_error_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          sample, bit_in, timeout;

    // Filtered clock only flips after FILTER_LEN cycles at the new level
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == 4'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end
    end

    assign sample  = filt_prev_q & ~filt_clk_q;
    assign bit_in  = dat_s2_q;
    assign timeout = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_ok_d   = parity_ok_q;
        scan_code_d   = scan_code_q;
        scan_ready_d  = 1'b0;
        frame_error_d = 1'b0;

        if (state_q == IDLE || sample) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end

        if (timeout) begin
            state_d       = IDLE;
            frame_error_d = 1'b1;
        end else if (sample) begin
            unique case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_ok_d = (^shift_q) ^ bit_in;
                    state_d     = STOP;
                end
                STOP: begin
                    if (bit_in && parity_ok_q) begin
                        scan_code_d  = shift_q;
                        scan_ready_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            filt_clk_q    <= 1'b1;
            filt_prev_q   <= 1'b1;
            filt_cnt_q    <= '0;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_ok_q   <= 1'b0;
            scan_code_q   <= '0;
            scan_ready_q  <= 1'b0;
            frame_error_q <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            clk_s1_q      <= bus.ps2_clk;
            clk_s2_q      <= clk_s1_q;
            dat_s1_q      <= bus.ps2_data;
            dat_s2_q      <= dat_s1_q;
            filt_clk_q    <= filt_clk_d;
            filt_prev_q   <= filt_clk_q;
            filt_cnt_q    <= filt_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_ok_q   <= parity_ok_d;
            scan_code_q   <= scan_code_d;
            scan_ready_q  <= scan_ready_d;
            frame_error_q <= frame_error_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign bus.scan_code   = scan_code_q;
    assign bus.scan_ready  = scan_ready_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_receiver.sv
// Directed PS/2 frames; expected pulses queued by the stimulus, checked by a monitor.
module tb_ps2_receiver;
    localparam int TO   = 1000;
    localparam int HALF = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps2_receiver_if bus();

    ps2_receiver #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       err;
        logic [7:0] code;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] last_good = 8'h00;
    logic       seen_busy;
    logic [10:0] f;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Each pulse cycle consumes one expectation; a stretched pulse leaves
    // an extra pop that either mismatches or finds the queue empty.
    always @(negedge clk) begin
        if (rst && (bus.scan_ready || bus.frame_error)) begin
            if (bus.scan_ready && bus.frame_error) chk("ready_err_excl", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, bus.scan_ready, bus.frame_error}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {31'd0, bus.frame_error}, {31'd0, e.err});
                chk("pulse_scan_code", {24'd0, bus.scan_code}, {24'd0, e.code});
            end
        end
    end

    function automatic logic [10:0] frm(input logic [7:0] d, input logic par, input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clk) bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_range(input logic [10:0] fr, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) ps2_bit(fr[i]);
    endtask

    task automatic expect_ok(input logic [7:0] d);
        sb.push_back({1'b0, d});
        last_good = d;
    endtask

    task automatic expect_err();
        sb.push_back({1'b1, last_good});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, bus.busy},        32'd0);
        chk({tag, "_code"},  {24'd0, bus.scan_code},   32'd0);
        chk({tag, "_ready"}, {31'd0, bus.scan_ready},  32'd0);
        chk({tag, "_err"},   {31'd0, bus.frame_error}, 32'd0);
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        idle(3);
        chk_all_zero("reset");
        rst = 1'b1;
        idle(5);

        // valid byte 0x1D, busy observed mid-frame
        f = frm(8'h1D, 1'b1, 1'b1);
        expect_ok(8'h1D);
        send_range(f, 0, 4);
        chk("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
        send_range(f, 5, 10);
        idle(20);
        chk("busy_after_frame", {31'd0, bus.busy}, 32'd0);
        chk("hold_1D", {24'd0, bus.scan_code}, 32'h1D);

        // break sequence, back to back
        expect_ok(8'hF0);
        expect_ok(8'h1D);
        send_range(frm(8'hF0, 1'b1, 1'b1), 0, 10);
        send_range(frm(8'h1D, 1'b1, 1'b1), 0, 10);
        idle(20);

        // parity error keeps previous code
        expect_err();
        send_range(frm(8'h1C, 1'b1, 1'b1), 0, 10);
        idle(20);
        chk("hold_after_parity_err", {24'd0, bus.scan_code}, 32'h1D);

        // bad stop bit
        expect_err();
        send_range(frm(8'h75, 1'b0, 1'b0), 0, 10);
        idle(20);

        // stall after 5 data bits -> timeout
        expect_err();
        send_range(frm(8'h75, 1'b0, 1'b1), 0, 5);
        chk("busy_stalled", {31'd0, bus.busy}, 32'd1);
        idle(TO + 20);
        chk("busy_after_timeout", {31'd0, bus.busy}, 32'd0);
        chk("hold_after_timeout", {24'd0, bus.scan_code}, 32'h1D);

        expect_ok(8'h75);
        send_range(frm(8'h75, 1'b0, 1'b1), 0, 10);
        idle(20);

        // 2-cycle glitch on idle line with data low
        seen_busy = 1'b0;
        @(negedge clk) bus.ps2_data = 1'b0;
        bus.ps2_clk = 1'b0;
        idle(2);
        bus.ps2_clk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            seen_busy = seen_busy | bus.busy;
        end
        chk("glitch_busy", {31'd0, seen_busy}, 32'd0);
        bus.ps2_data = 1'b1;
        idle(5);

        // reset after 4 data bits of 0x6B
        f = frm(8'h6B, 1'b0, 1'b1);
        send_range(f, 0, 4);
        chk("busy_before_reset", {31'd0, bus.busy}, 32'd1);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        chk_all_zero("midreset");
        last_good = 8'h00;
        idle(5);
        expect_ok(8'h6B);
        send_range(f, 0, 10);
        idle(20);
        chk("final_code", {24'd0, bus.scan_code}, 32'h6B);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Deserializes the PS/2 device-to-host serial stream (ps2_clk / ps2_data pins) into 8-bit scan codes for the keyboard decode stage. It sits directly upstream of the keyboard decoder and drives that stage's scan_code / scan_ready inputs. Each valid byte produces exactly one single-cycle scan_ready pulse. Malformed or stalled frames are discarded and flagged on frame_error.

## Interface
- FILTER_LEN, 4: consecutive identical synchronized samples required before the filtered ps2_clk changes level (range 1–15).
- TIMEOUT_CYCLES, 50000: system-clock cycles allowed between sample events inside a frame before the frame is aborted (1 ms at 50 MHz).

- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-low.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous, idles high.
- ps2_data  input  1  raw PS/2 data pin, asynchronous, idles high.
- scan_code  output  8  last validly received byte; holds until the next valid frame.
- scan_ready  output  1  one-cycle pulse when scan_code has just been updated.
- frame_error  output  1  one-cycle pulse when a frame is discarded.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- Synchronization: ps2_clk and ps2_data each pass through a 2-flop synchronizer.
- Glitch filter: filt_clk (reset value 1) takes the synchronized clock level only after FILTER_LEN consecutive cycles at that new level. A shorter excursion leaves filt_clk unchanged.
- Sample event: the cycle in which filt_clk goes 1→0. The data bit is the synchronized ps2_data value in that cycle.
- Frame format: start bit 0, then 8 data bits LSB first, then an odd-parity bit, then stop bit 1.
- FSM states are IDLE, DATA, PARITY and STOP.
  - IDLE: on a sample event with bit=0, go to DATA and clear bit_cnt. With bit=1, stay in IDLE, discard silently, no error.
  - DATA: shift the bit into shift_reg[7] (right shift) and increment bit_cnt (3-bit). On the 8th bit (bit_cnt==7), go to PARITY.
  - PARITY: parity_ok = (^shift_reg) ^ bit. 1 means odd parity holds. Go to STOP.
  - STOP: on a sample event, if bit==1 and parity_ok, load scan_code with shift_reg and pulse scan_ready. Otherwise pulse frame_error and leave scan_code unchanged. Go to IDLE in both cases.
- Timeout: an idle counter clears on every sample event and increments each cycle while the FSM is not in IDLE. When it reaches TIMEOUT_CYCLES, go to IDLE, pulse frame_error, and do not pulse scan_ready. The counter saturates and is held at 0 in IDLE.
- scan_ready and frame_error are never high in the same cycle.
- No back-pressure: the downstream stage must sample scan_code while scan_ready is high. scan_code remains stable afterwards until the next valid frame.
- Reset (rst==0 at a clk edge):
  - state goes to IDLE; bit_cnt, shift_reg, scan_code and counters go to 0.
  - scan_ready, frame_error and busy go to 0.
  - synchronizer flops and filt_clk go to 1.
  - A reset asserted mid-frame aborts the frame with no pulses. The following frame decodes normally.

## Timing
- Pin-to-event latency: a ps2_clk pin fall produces a sample event 2 + FILTER_LEN cycles later, with ±1 cycle of synchronizer uncertainty.
- scan_ready / frame_error: registered, high for exactly one cycle, asserted in the cycle after the stop-bit sample event (or the timeout event).
- busy: rises the cycle after the start-bit sample event. It falls in the same cycle that scan_ready or frame_error rises.
- Back-to-back frames: no dead cycles are required. A start-bit sample event in the first cycle after returning to IDLE is accepted.
- Throughput: one byte per 11 PS/2 clocks (10–16.7 kHz), far below the clk rate.

## Test plan
- Valid byte: send 0x1D with parity 1 and stop 1 (FILTER_LEN=4) -> busy high during the frame; scan_code=0x1D; scan_ready high for exactly 1 cycle; frame_error stays 0.
- Break sequence back-to-back: send 0xF0 (parity 1) immediately followed by 0x1D -> two scan_ready pulses, with scan_code=0xF0 then 0x1D. scan_code is 0xF0 during the first pulse.
- Parity error: send 0x1C with parity 1 (correct parity is 0) -> frame_error single pulse; no scan_ready; scan_code keeps its previous value (e.g. 0x1D).
- Bad stop / timeout: send 0x75 with stop bit 0 -> frame_error pulse. Then stop a frame after 5 data bits and idle TIMEOUT_CYCLES+2 cycles -> frame_error pulse, busy=0. Then a clean 0x75 -> scan_code=0x75 with a scan_ready pulse.
- Glitch rejection: with the line idle, drive a 2-cycle low pulse on ps2_clk while ps2_data=0 -> no state change, busy stays 0, no pulses.
- Reset mid-frame: drive rst=0 for 1 cycle after 4 data bits of 0x6B -> all outputs 0 the next cycle, no pulses. A subsequent full frame 0x6B -> scan_code=0x6B with a scan_ready pulse.
